// File: rtl/aes_round_controller_if.sv
// Control interface between the encryption request logic and the AES round
// controller. The master side raises start/cancel requests; the slave side
// (the controller) returns the datapath strobes, selects and round index.
interface aes_round_controller_if #(
  parameter int RW = 4
);
  logic          encryptEnable;
  logic          abort;
  logic          keyLoad;
  logic          keyExpand;
  logic [RW-1:0] roundNum;
  logic          selInitial;
  logic          roundKeyEn;
  logic          mixEn;
  logic          stateLoad;
  logic          outputLoad;
  logic          busy;
  logic          done;

  modport master (
    output encryptEnable, abort,
    input  keyLoad, keyExpand, roundNum, selInitial, roundKeyEn,
           mixEn, stateLoad, outputLoad, busy, done
  );

  modport slave (
    input  encryptEnable, abort,
    output keyLoad, keyExpand, roundNum, selInitial, roundKeyEn,
           mixEn, stateLoad, outputLoad, busy, done
  );
endinterface

// File: rtl/aes_round_controller.sv
// Moore FSM sequencing the AES encryption datapath: key/plaintext capture,
// key expansion, the initial AddRoundKey, the middle rounds with MixColumns
// and the final round without it. Only strobes, selects and the round index
// leave this block; the datapath itself is purely combinational.
module aes_round_controller #(
  parameter int NUM_ROUNDS = 10,
  parameter int RW         = 4
) (
  input logic                   clk,
  input logic                   n_rst,
  aes_round_controller_if.slave ctrl
);

  // Only the three AES key sizes are meaningful, and roundNum must be able
  // to hold the final round index.
  if (!(NUM_ROUNDS == 10 || NUM_ROUNDS == 12 || NUM_ROUNDS == 14)) begin : gen_bad_rounds
    $error("aes_round_controller: NUM_ROUNDS must be 10, 12 or 14");
  end
  if ((1 << RW) <= NUM_ROUNDS) begin : gen_bad_width
    $error("aes_round_controller: RW too narrow for NUM_ROUNDS");
  end

  localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS);
  localparam logic [RW-1:0] ROUND_ONE  = RW'(1);
  localparam logic [RW-1:0] ROUND_ZERO = '0;

  typedef enum logic [3:0] {
    IDLE,
    KEY_SCHEDULE,
    START,
    WAIT_1,
    ROUND_KEY,
    MIX_COLUMN,
    CONTROL_OUTPUT,
    FINAL_ROUND,
    DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [RW-1:0] round_q;
  logic [RW-1:0] round_d;
  logic [RW-1:0] round_inc;

  // State and round-index registers; reset drops straight back to IDLE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      round_q <= ROUND_ZERO;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Next-state and next-round logic; abort overrides everything outside IDLE.
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    round_inc = round_q + ROUND_ONE;
    case (state_q)
      IDLE: begin
        round_d = ROUND_ZERO;
        if (ctrl.encryptEnable) begin
          state_d = KEY_SCHEDULE;
        end
      end
      KEY_SCHEDULE: state_d = START;
      START:        state_d = WAIT_1;
      WAIT_1:       state_d = ROUND_KEY;
      ROUND_KEY: begin
        if (round_q == ROUND_ZERO) begin
          state_d = CONTROL_OUTPUT;
        end else begin
          state_d = MIX_COLUMN;
        end
      end
      MIX_COLUMN:   state_d = CONTROL_OUTPUT;
      CONTROL_OUTPUT: begin
        round_d = round_inc;
        if (round_inc < LAST_ROUND) begin
          state_d = ROUND_KEY;
        end else begin
          state_d = FINAL_ROUND;
        end
      end
      FINAL_ROUND: begin
        round_d = LAST_ROUND;
        state_d = DONE;
      end
      DONE: begin
        round_d = ROUND_ZERO;
        state_d = IDLE;
      end
      default: begin
        round_d = ROUND_ZERO;
        state_d = IDLE;
      end
    endcase
    if (ctrl.abort && state_q != IDLE) begin
      state_d = IDLE;
      round_d = ROUND_ZERO;
    end
  end

  // Moore output decode from the state register and round index only.
  always_comb begin
    ctrl.keyLoad    = 1'b0;
    ctrl.keyExpand  = 1'b0;
    ctrl.roundNum   = round_q;
    ctrl.selInitial = 1'b0;
    ctrl.roundKeyEn = 1'b0;
    ctrl.mixEn      = 1'b0;
    ctrl.stateLoad  = 1'b0;
    ctrl.outputLoad = 1'b0;
    ctrl.busy       = (state_q != IDLE);
    ctrl.done       = 1'b0;
    case (state_q)
      IDLE: begin
        ctrl.roundNum = ROUND_ZERO;
      end
      KEY_SCHEDULE: begin
        ctrl.keyLoad   = 1'b1;
        ctrl.keyExpand = 1'b1;
      end
      START: begin
        ctrl.keyExpand = 1'b1;
      end
      ROUND_KEY: begin
        ctrl.roundKeyEn = 1'b1;
        ctrl.selInitial = (round_q == ROUND_ZERO);
      end
      MIX_COLUMN: begin
        ctrl.mixEn = 1'b1;
      end
      CONTROL_OUTPUT: begin
        ctrl.stateLoad = 1'b1;
        ctrl.mixEn     = (round_q != ROUND_ZERO);
      end
      FINAL_ROUND: begin
        ctrl.roundNum   = LAST_ROUND;
        ctrl.roundKeyEn = 1'b1;
        ctrl.stateLoad  = 1'b1;
        ctrl.outputLoad = 1'b1;
      end
      DONE: begin
        ctrl.done = 1'b1;
      end
      default: begin
        ctrl.roundNum = round_q;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_round_controller.sv
// Self-checking bench for aes_round_controller with NUM_ROUNDS=10: a
// per-cycle vector table for one full encryption, then hand-written
// sequences for back-to-back runs, requests while busy, abort and reset.
module tb_aes_round_controller;

  localparam int NR = 10;
  localparam int RW = 4;

  logic tb_clk = 1'b0;
  logic n_rst;
  int   checks   = 0;
  int   failures = 0;
  int   doneAt[$];

  typedef struct {
    logic        encryptEnable;
    logic        abort;
    logic [12:0] expected;
  } vector_t;

  vector_t vec[0:35];

  aes_round_controller_if #(.RW(RW)) bus ();

  aes_round_controller #(.NUM_ROUNDS(NR), .RW(RW)) dut (
    .clk  (tb_clk),
    .n_rst(n_rst),
    .ctrl (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 tb_clk = ~tb_clk;

  // Safety net so the run always ends even if the controller locks up.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    failures++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [12:0] pack(input logic kl, input logic ke, input logic si,
                                       input logic rk, input logic mx, input logic sl,
                                       input logic ol, input logic bz, input logic dn,
                                       input int rn);
    return {kl, ke, si, rk, mx, sl, ol, bz, dn, 4'(rn)};
  endfunction

  // Expected outputs during cycle c after the edge that samples encryptEnable.
  function automatic logic [12:0] expectedAt(input int c);
    int r;
    int ph;
    if (c <= 0 || c >= 35) return 13'd0;
    if (c == 1) return pack(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    if (c == 2) return pack(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    if (c == 3) return pack(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    if (c == 4) return pack(0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    if (c == 5) return pack(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    if (c <= 32) begin
      r  = (c - 6) / 3 + 1;
      ph = (c - 6) % 3;
      if (ph == 0) return pack(0, 0, 0, 1, 0, 0, 0, 1, 0, r);
      if (ph == 1) return pack(0, 0, 0, 0, 1, 0, 0, 1, 0, r);
      return pack(0, 0, 0, 0, 1, 1, 0, 1, 0, r);
    end
    if (c == 33) return pack(0, 0, 0, 1, 0, 1, 1, 1, 0, 10);
    return pack(0, 0, 0, 0, 0, 0, 0, 1, 1, 10);
  endfunction

  function automatic logic [12:0] observed();
    return {bus.keyLoad, bus.keyExpand, bus.selInitial, bus.roundKeyEn, bus.mixEn,
            bus.stateLoad, bus.outputLoad, bus.busy, bus.done, bus.roundNum};
  endfunction

  task automatic applyStimulus(input logic en, input logic ab);
    bus.encryptEnable = en;
    bus.abort         = ab;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Runs one request (already applied by the caller) for a bounded window.
  task automatic runBlock(input int limit, output int doneCycle, output int doneCount,
                          output int loadCount);
    doneCycle = -1;
    doneCount = 0;
    loadCount = 0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge tb_clk);
      if (k == 1) applyStimulus(1'b0, 1'b0);
      if (bus.done) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = k;
      end
      if (bus.outputLoad) loadCount++;
    end
  endtask

  task automatic drainToIdle();
    for (int k = 0; k < 200 && bus.busy; k++) begin
      @(negedge tb_clk);
    end
    checkOutput("drain_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int dc;
    int dn;
    int ol;
    int busyLow;
    int busyHigh;
    int gap1;
    int gap2;
    logic busy35;

    n_rst = 1'b0;
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i <= 35; i++) begin
      vec[i].encryptEnable = (i == 0);
      vec[i].abort         = 1'b0;
      vec[i].expected      = expectedAt(i);
    end

    #2;
    checkOutput("reset_outputs", 32'(observed()), 32'd0);
    @(negedge tb_clk);
    n_rst = 1'b1;
    @(negedge tb_clk);

    // One full encryption, checked cycle by cycle.
    for (int i = 0; i <= 35; i++) begin
      checkOutput($sformatf("vector_cycle%0d", i), 32'(observed()), 32'(vec[i].expected));
      applyStimulus(vec[i].encryptEnable, vec[i].abort);
      @(negedge tb_clk);
    end

    // Back-to-back: encryptEnable held high.
    applyStimulus(1'b1, 1'b0);
    busyLow = 0;
    for (int k = 1; k <= 110; k++) begin
      @(negedge tb_clk);
      if (bus.done) doneAt.push_back(k);
      if (!bus.busy) busyLow++;
    end
    applyStimulus(1'b0, 1'b0);
    gap1 = -1;
    gap2 = -1;
    dc   = -1;
    if (doneAt.size() >= 3) begin
      dc   = doneAt[0];
      gap1 = doneAt[1] - doneAt[0];
      gap2 = doneAt[2] - doneAt[1];
    end
    checkOutput("b2b_done_count", 32'(doneAt.size()), 32'd3);
    checkOutput("b2b_first_done", 32'(dc), 32'd34);
    checkOutput("b2b_gap1", 32'(gap1), 32'd35);
    checkOutput("b2b_gap2", 32'(gap2), 32'd35);
    checkOutput("b2b_idle_cycles", 32'(busyLow), 32'd3);
    drainToIdle();

    // Requests while busy are ignored.
    applyStimulus(1'b1, 1'b0);
    dn = 0;
    dc = -1;
    busyHigh = 0;
    busy35 = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge tb_clk);
      applyStimulus((k == 5 || k == 20 || k == 33), 1'b0);
      if (bus.done) begin
        dn++;
        dc = k;
      end
      if (bus.busy) busyHigh++;
      if (k == 35) busy35 = bus.busy;
    end
    checkOutput("busy_req_done_count", 32'(dn), 32'd1);
    checkOutput("busy_req_done_cycle", 32'(dc), 32'd34);
    checkOutput("busy_req_busy_cycles", 32'(busyHigh), 32'd34);
    checkOutput("busy_req_idle_after_done", 32'(busy35), 32'd0);

    // Abort in cycle 10, then a fresh request completes normally.
    applyStimulus(1'b1, 1'b0);
    dn = 0;
    ol = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge tb_clk);
      if (k == 1) applyStimulus(1'b0, 1'b0);
      if (k == 10) applyStimulus(1'b0, 1'b1);
      if (k == 11) begin
        checkOutput("abort_idle", 32'(observed()), 32'd0);
        applyStimulus(1'b0, 1'b0);
      end
      if (bus.done) dn++;
      if (bus.outputLoad) ol++;
    end
    checkOutput("abort_no_done", 32'(dn), 32'd0);
    checkOutput("abort_no_outputload", 32'(ol), 32'd0);
    applyStimulus(1'b1, 1'b0);
    runBlock(40, dc, dn, ol);
    checkOutput("post_abort_done_cycle", 32'(dc), 32'd34);
    checkOutput("post_abort_done_count", 32'(dn), 32'd1);
    checkOutput("post_abort_outputload", 32'(ol), 32'd1);

    // Abort during FINAL_ROUND: outputLoad seen, but no done.
    applyStimulus(1'b1, 1'b0);
    dn = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge tb_clk);
      if (k == 1) applyStimulus(1'b0, 1'b0);
      if (k == 33) begin
        checkOutput("final_outputload", 32'(observed()), 32'(expectedAt(33)));
        applyStimulus(1'b0, 1'b1);
      end
      if (k == 34) begin
        checkOutput("final_abort_idle", 32'(observed()), 32'd0);
        applyStimulus(1'b0, 1'b0);
      end
      if (bus.done) dn++;
    end
    checkOutput("final_abort_no_done", 32'(dn), 32'd0);

    // abort with encryptEnable in IDLE still starts; abort in KEY_SCHEDULE cancels.
    applyStimulus(1'b1, 1'b1);
    @(negedge tb_clk);
    checkOutput("abort_enable_start", 32'(observed()), 32'(expectedAt(1)));
    applyStimulus(1'b0, 1'b1);
    @(negedge tb_clk);
    checkOutput("abort_keyschedule", 32'(observed()), 32'd0);
    applyStimulus(1'b0, 1'b0);
    @(negedge tb_clk);

    // Reset asserted during round 5, then a normal run.
    applyStimulus(1'b1, 1'b0);
    for (int k = 1; k <= 19; k++) begin
      @(negedge tb_clk);
      if (k == 1) applyStimulus(1'b0, 1'b0);
    end
    checkOutput("round5_mix", 32'(observed()), 32'(expectedAt(19)));
    #1 n_rst = 1'b0;
    #1 checkOutput("reset_midround", 32'(observed()), 32'd0);
    @(negedge tb_clk);
    n_rst = 1'b1;
    @(negedge tb_clk);
    applyStimulus(1'b1, 1'b0);
    runBlock(40, dc, dn, ol);
    checkOutput("post_reset_done_cycle", 32'(dc), 32'd34);
    checkOutput("post_reset_done_count", 32'(dn), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_round_controller.md
Name: aes_round_controller

Overview:
- Moore FSM that sequences the AES-128 encryption datapath: key/plaintext capture, key expansion, the initial AddRoundKey, rounds 1..NUM_ROUNDS-1 (with MixColumns) and the final round (no MixColumns).
- Sits inside encryption_block between the encryptEnable request and the combinational round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey, key expansion).
- Drives only strobes, selects and the round index; the datapath itself holds no control logic.

Parameters:
- NUM_ROUNDS, 10: number of AES rounds. Legal values 10, 12, 14; any other value is an elaboration error.
- RW, 4: width of roundNum; must satisfy 2^RW > NUM_ROUNDS.

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- encryptEnable  in  1  start request; level sampled only in IDLE
- abort  in  1  synchronous cancel; honoured in any non-IDLE state
- keyLoad  out  1  capture key and inputData into datapath registers
- keyExpand  out  1  enable the key-schedule registers
- roundNum  out  RW  round-key index for AddRoundKey (0..NUM_ROUNDS)
- selInitial  out  1  state mux selects captured inputData (round 0 only)
- roundKeyEn  out  1  AddRoundKey stage active
- mixEn  out  1  MixColumns in path (0 = bypass)
- stateLoad  out  1  write round result into the state register
- outputLoad  out  1  write final result into the outputData register
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse; outputData is valid while high

Behaviour:
- Reset (n_rst=0, asynchronous): state=IDLE, roundNum=0, all outputs 0. outputData in the datapath is not cleared by this block.
- States, one cycle each unless noted: IDLE, KEY_SCHEDULE, START, WAIT_1, ROUND_KEY, MIX_COLUMN, CONTROL_OUTPUT, FINAL_ROUND, DONE.
- IDLE: roundNum held at 0. Moves to KEY_SCHEDULE when encryptEnable=1 at the clock edge; otherwise stays in IDLE.
- KEY_SCHEDULE: keyLoad=1, keyExpand=1.
- START: keyExpand=1.
- WAIT_1: no strobes. Gives the expanded keys time to settle.
- ROUND_KEY: roundKeyEn=1, selInitial=(roundNum==0).
  - Next state is CONTROL_OUTPUT when roundNum==0, otherwise MIX_COLUMN.
- MIX_COLUMN: mixEn=1.
- CONTROL_OUTPUT: stateLoad=1, mixEn=(roundNum!=0).
  - roundNum increments at the exit edge.
  - Next state is ROUND_KEY if the incremented value is < NUM_ROUNDS, otherwise FINAL_ROUND.
- FINAL_ROUND: roundNum=NUM_ROUNDS, roundKeyEn=1, mixEn=0, stateLoad=1, outputLoad=1.
- DONE: done=1. Next state is always IDLE, and roundNum is cleared to 0 on that edge.
- Outputs are decoded from the state register and roundNum only (Moore); there are no combinational paths from inputs to outputs.
- Latency: done is high during the (3*NUM_ROUNDS+4)th cycle after the edge that samples encryptEnable=1. For NUM_ROUNDS=10 this is cycle 34.
- Throughput: with encryptEnable held high, DONE is followed by one IDLE cycle, so one block completes every 3*NUM_ROUNDS+5 cycles (35 for NUM_ROUNDS=10).
- encryptEnable is ignored while busy=1. Requests are not queued, and a pulse that never lands in IDLE is lost.
- abort=1 in any non-IDLE state: next state is IDLE, roundNum returns to 0, and neither outputLoad nor done fires.
  - If the current state is FINAL_ROUND, its outputLoad has already fired in that cycle. The next state is still IDLE and done does not fire.
- abort=1 in IDLE has no effect. When abort and encryptEnable are both high in IDLE, the controller still starts.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No partial done.
- roundNum never exceeds NUM_ROUNDS. An unreachable state encoding recovers to IDLE on the next edge.

Test Plan:
- Reset: assert n_rst=0 mid-cycle -> all outputs and roundNum read 0 before the next clock edge; busy=0.
- Single block (integrated in encryption_block, NUM_ROUNDS=10): key=5E74E7BA66B0C7CC1B7697B3F9F51527, data=7D8AE0F7CFA0A6CB09FB5D05A8EC586D, encryptEnable pulsed for 1 cycle -> done high in exactly cycle 34, outputData=deb0f81341f3503a7cd01e2bc7cdd556. Check the round sequence: roundNum takes 0..10 in order, mixEn=0 at round 0 and round 10, keyLoad pulses exactly once.
- Back-to-back: encryptEnable held high, key=33DE20E331BA5A525AB7C2495A767B5A, data=E6FEBF30133874EBCB49226CD36D0D4F -> done pulses every 35 cycles, each result=67928dd5470d4a11f0ea4ae7d49b2dd4.
- Request while busy: pulse encryptEnable in cycles 5, 20 and 33 of an encryption -> exactly one done, no restart, busy falls for 1 cycle after DONE.
- Abort: abort=1 in cycle 10 -> IDLE on the next edge, roundNum=0, no done and no outputLoad. A new request then completes normally with key=EED5A3496E321A41C925F0389B236E36, data=D07A7228CF5E1ED034E14FA06FA08D49 -> output 71D31B8BA309FF7ABF61A6938CFA4267.
- Reset mid-round: n_rst low during round 5 -> outputs 0 immediately. After release, key=AD711EC0ACD35F80C3E5EDD4E1336B6A, data=C0C148CF7C52DC9A10CCAB979FF03920 -> 0EA6416862183B71C5A2B66E320FDDEB with done in cycle 34.
